// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC sequencer issuing MEM_DW-wide beats, assembling 32-bit words into a QDEPTH FIFO.
// Defining FETCH_PERF_CNT_EN adds the inst_cnt_o retired-fetch counter.
module if_fetch_queue #(
  parameter int XLEN = 32,
  parameter int MEM_DW = 8,
  parameter int MEM_LAT = 2,
  parameter int QDEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [XLEN-1:0]   branch_target_i,
  output logic              mem_ce_o,
  output logic [XLEN-1:0]   mem_addr_o,
  input  logic [MEM_DW-1:0] mem_data_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   inst_pc_o,
  input  logic              inst_ready_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       inst_cnt_o
`endif
);
  localparam int BEATS = 32 / MEM_DW;
  localparam int BSTEP = MEM_DW / 8;
  localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int AW = $clog2(QDEPTH);
  localparam logic [KW-1:0] KLAST = KW'(BEATS - 1);
  localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t r_state, w_state;
  logic [KW-1:0] r_k, w_k;
  logic r_force, r_inflight;
  logic [XLEN-1:0] r_pc;
  logic r_v [MEM_LAT];
  logic [KW-1:0] r_kq [MEM_LAT];
  logic [31:0] r_asm, w_word;
  logic [31:0] r_ins [QDEPTH];
  logic [XLEN-1:0] r_ipc [QDEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_cnt, w_cnt;
  logic w_issue, w_last, w_push, w_pop, w_start;

  // r_force lets the first target beat go out even under stall
  assign w_issue = !rst && r_state == ISSUE && (r_force || !stall_i);
  assign w_last = r_v[MEM_LAT-1] && r_kq[MEM_LAT-1] == KLAST;
  assign w_push = w_last && !branch_i;
  assign w_pop = inst_valid_o && inst_ready_i && !branch_i;
  assign w_cnt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  // Start from post-capture occupancy so a fetch can follow its own last beat back-to-back
  assign w_start = !stall_i && !(r_inflight && !w_last) && w_cnt < QFULL;

  always_comb begin
    w_word = r_asm;
    w_word[r_kq[MEM_LAT-1]*MEM_DW +: MEM_DW] = mem_data_i;
  end

  always_comb begin
    w_state = r_state;
    w_k = r_k;
    if (branch_i) begin
      w_state = ISSUE;
      w_k = '0;
    end else if (r_state == IDLE) begin
      w_state = w_start ? ISSUE : IDLE;
    end else if (w_issue) begin
      w_state = r_k == KLAST ? IDLE : ISSUE;
      w_k = r_k == KLAST ? '0 : r_k + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ISSUE;
      r_k <= '0;
      r_force <= 1'b0;
      r_inflight <= 1'b0;
      r_pc <= RESET_PC;
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_k <= w_k;
      r_force <= branch_i;
      r_pc <= branch_i ? branch_target_i : w_push ? r_pc + XLEN'(4) : r_pc;
      r_inflight <= branch_i ? 1'b0 : (w_issue && r_k == KLAST) ? 1'b1 : w_last ? 1'b0 : r_inflight;
      r_rd <= branch_i ? '0 : r_rd + AW'(w_pop);
      r_wr <= branch_i ? '0 : r_wr + AW'(w_push);
      r_cnt <= branch_i ? '0 : w_cnt;
    end
  end

  // Fixed-latency return tracker: one {valid, beat index} slot per pipeline stage
  always_ff @(posedge clk) begin
    r_v[0] <= !rst && !branch_i && w_issue;
    r_kq[0] <= r_k;
    for (int i = 1; i < MEM_LAT; i++) begin
      r_v[i] <= !rst && !branch_i && r_v[i-1];
      r_kq[i] <= r_kq[i-1];
    end
    r_asm <= r_v[MEM_LAT-1] ? w_word : r_asm;
    if (w_push) begin
      r_ins[r_wr] <= w_word;
      r_ipc[r_wr] <= r_pc;
    end
  end

  assign mem_ce_o = w_issue;
  assign mem_addr_o = w_issue ? r_pc + XLEN'(r_k) * XLEN'(BSTEP) : '0;
  assign inst_valid_o = r_cnt != '0;
  assign inst_o = inst_valid_o ? r_ins[r_rd] : '0;
  assign inst_pc_o = inst_valid_o ? r_ipc[r_rd] : '0;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) inst_cnt_o <= rst ? '0 : inst_cnt_o + 32'(w_pop);
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: cycle table after reset, corner sequences, randomized run against an instruction-stream model.
module tb_if_fetch_queue;
  logic clk = 0, rst = 1, stall_i = 0, branch_i = 0, inst_ready_i = 0;
  logic [31:0] branch_target_i = 0;
  logic mem_ce_o, inst_valid_o;
  logic [31:0] mem_addr_o, inst_o, inst_pc_o;
  logic [7:0] mem_data_i;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] inst_cnt_o;
`endif
  int checks = 0, errors = 0, npop = 0;
  logic [31:0] exp_pc = 0;
  logic last_br = 0;
  logic [31:0] a_pipe [2];

  typedef struct {
    logic stall; logic ready;
    logic ce; logic [31:0] addr; logic valid; logic [31:0] pc; logic [31:0] inst;
  } vec_t;
  vec_t tv [13];

  if_fetch_queue dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_ready_i(inst_ready_i)
`ifdef FETCH_PERF_CNT_EN
    , .inst_cnt_o(inst_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    case (a)
      32'd0: return 8'h13;
      32'd4: return 8'h93;
      32'd6: return 8'h10;
      32'd1, 32'd2, 32'd3, 32'd5, 32'd7: return 8'h00;
      default: return (lo * 8'd7) ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return {byte_at(p + 32'd3), byte_at(p + 32'd2), byte_at(p + 32'd1), byte_at(p)};
  endfunction

  // Memory with two-cycle read latency
  always @(posedge clk) begin
    a_pipe[0] <= mem_addr_o;
    a_pipe[1] <= a_pipe[0];
  end
  assign mem_data_i = byte_at(a_pipe[1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Stream model: accepted words come from consecutive PCs, restarting at a branch target
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 0;
      npop = 0;
    end else if (branch_i) begin
      exp_pc = branch_target_i;
    end else if (inst_valid_o && inst_ready_i) begin
      chk("pop_pc", inst_pc_o, exp_pc);
      chk("pop_inst", inst_o, word_at(inst_pc_o));
      exp_pc = inst_pc_o + 32'd4;
      npop++;
    end
    if (!rst && stall_i && !last_br) chk("stall_ce", {31'd0, mem_ce_o}, 0);
    last_br = branch_i;
  end

  task automatic do_reset(input logic rdy);
    rst = 1; stall_i = 0; branch_i = 0; inst_ready_i = rdy;
    nxt();
    nxt();
    @(negedge clk);
    chk("rst_ce", {31'd0, mem_ce_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_valid", {31'd0, inst_valid_o}, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", inst_pc_o, 0);
    nxt();
    rst = 0;
  endtask

  initial begin
    int nb;
    logic found;
    logic [31:0] cnt0;
    tv[0]  = '{0, 1, 1, 32'h0, 0, 0, 0};
    tv[1]  = '{0, 1, 1, 32'h1, 0, 0, 0};
    tv[2]  = '{0, 1, 1, 32'h2, 0, 0, 0};
    tv[3]  = '{0, 1, 1, 32'h3, 0, 0, 0};
    tv[4]  = '{0, 1, 0, 32'h0, 0, 0, 0};
    tv[5]  = '{0, 1, 0, 32'h0, 0, 0, 0};
    tv[6]  = '{0, 1, 1, 32'h4, 1, 32'h0, 32'h00000013};
    tv[7]  = '{0, 1, 1, 32'h5, 0, 0, 0};
    tv[8]  = '{0, 1, 1, 32'h6, 0, 0, 0};
    tv[9]  = '{0, 1, 1, 32'h7, 0, 0, 0};
    tv[10] = '{0, 1, 0, 32'h0, 0, 0, 0};
    tv[11] = '{0, 1, 0, 32'h0, 0, 0, 0};
    tv[12] = '{0, 1, 1, 32'h8, 1, 32'h4, 32'h00100093};
    cnt0 = 0;

    do_reset(1);
    for (int i = 0; i < 13; i++) begin
      stall_i = tv[i].stall;
      inst_ready_i = tv[i].ready;
      @(negedge clk);
      chk("t1_ce", {31'd0, mem_ce_o}, {31'd0, tv[i].ce});
      if (tv[i].ce) chk("t1_addr", mem_addr_o, tv[i].addr);
      chk("t1_valid", {31'd0, inst_valid_o}, {31'd0, tv[i].valid});
      if (tv[i].valid) begin
        chk("t1_pc", inst_pc_o, tv[i].pc);
        chk("t1_inst", inst_o, tv[i].inst);
      end
      nxt();
    end

    do_reset(0);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_ce_o) begin
        chk("t2_addr", mem_addr_o, nb);
        nb++;
      end
      nxt();
    end
    chk("t2_beats", nb, 16);
    @(negedge clk);
    chk("t2_head_valid", {31'd0, inst_valid_o}, 1);
    chk("t2_head_pc", inst_pc_o, 0);
    nxt();
    inst_ready_i = 1;
    @(negedge clk);
    nxt();
    inst_ready_i = 0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ce_o) begin
        chk("t2_refetch_addr", mem_addr_o, 32'd16 + nb);
        nb++;
      end
      nxt();
    end
    chk("t2_refetch_beats", nb, 4);
    @(negedge clk);
    chk("t2_next_head_pc", inst_pc_o, 4);
    nxt();

    do_reset(1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (mem_ce_o && mem_addr_o == 32'h9) found = 1;
      nxt();
    end
    chk("t3_found_k1", {31'd0, found}, 1);
    branch_i = 1;
    branch_target_i = 32'h40;
    @(negedge clk);
    chk("t3_k2_addr", mem_addr_o, 32'hA);
    nxt();
    branch_i = 0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j == 1) begin
        chk("t3_tgt_ce", {31'd0, mem_ce_o}, 1);
        chk("t3_tgt_addr", mem_addr_o, 32'h40);
      end
      chk("t3_valid", {31'd0, inst_valid_o}, {31'd0, j == 7});
      if (j == 7) chk("t3_pc", inst_pc_o, 32'h40);
      nxt();
    end

    do_reset(1);
    @(negedge clk);
    chk("t4_a0", mem_addr_o, 0);
    nxt();
    @(negedge clk);
    chk("t4_a1", mem_addr_o, 1);
    nxt();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stalled_ce", {31'd0, mem_ce_o}, 0);
      nxt();
    end
    stall_i = 0;
    @(negedge clk);
    chk("t4_resume_ce", {31'd0, mem_ce_o}, 1);
    chk("t4_a2", mem_addr_o, 2);
    nxt();
    @(negedge clk);
    chk("t4_a3", mem_addr_o, 3);
    nxt();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (inst_valid_o) begin
        found = 1;
        chk("t4_inst", inst_o, 32'h00000013);
        chk("t4_pc", inst_pc_o, 0);
      end
      nxt();
    end
    chk("t4_word_seen", {31'd0, found}, 1);

    do_reset(0);
    repeat (40) nxt();
    @(negedge clk);
    chk("t5_full_ce", {31'd0, mem_ce_o}, 0);
    chk("t5_full_valid", {31'd0, inst_valid_o}, 1);
`ifdef FETCH_PERF_CNT_EN
    cnt0 = inst_cnt_o;
`endif
    nxt();
    stall_i = 1; branch_i = 1; branch_target_i = 32'h80; inst_ready_i = 1;
    @(negedge clk);
    nxt();
    branch_i = 0; inst_ready_i = 0;
    @(negedge clk);
    chk("t5_flushed", {31'd0, inst_valid_o}, 0);
    chk("t5_forced_ce", {31'd0, mem_ce_o}, 1);
    chk("t5_tgt_addr", mem_addr_o, 32'h80);
`ifdef FETCH_PERF_CNT_EN
    chk("t5_cnt", inst_cnt_o, cnt0);
`endif
    nxt();
    @(negedge clk);
    chk("t5_stall_after", {31'd0, mem_ce_o}, 0);
    nxt();
    stall_i = 0;
    @(negedge clk);
    chk("t5_resume_addr", mem_addr_o, 32'h81);
    nxt();

    do_reset(1);
    repeat (4) nxt();
    rst = 1;
    nxt();
    rst = 0;
    @(negedge clk);
    chk("t6_valid0", {31'd0, inst_valid_o}, 0);
    chk("t6_inst0", inst_o, 0);
    chk("t6_pc0", inst_pc_o, 0);
    chk("t6_ce", {31'd0, mem_ce_o}, 1);
    chk("t6_addr", mem_addr_o, 0);
    nxt();
    for (int j = 2; j <= 7; j++) begin
      @(negedge clk);
      chk("t6_valid", {31'd0, inst_valid_o}, {31'd0, j == 7});
      if (j == 7) chk("t6_first_pc", inst_pc_o, 0);
      nxt();
    end

    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      stall_i = ($urandom % 4) == 0;
      inst_ready_i = ($urandom % 3) != 0;
      branch_i = (i == 5) || (($urandom % 50) == 0);
      branch_target_i = (i == 5) ? 32'hFFFFFFFE : $urandom;
      nxt();
    end
    branch_i = 0; stall_i = 0; inst_ready_i = 0;
    nxt();
    nxt();
    @(negedge clk);
    chk("rnd_progress", {31'd0, npop > 100}, 1);
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_cnt", inst_cnt_o, npop);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
